// File: rtl/tmds_pkg.sv
// Shared TMDS symbol constants and alignment state type, used by both the
// transmit encoder and the receive decoder.
package tmds_pkg;

   localparam int SYM_W = 10;

   localparam logic [SYM_W-1:0] TOKEN_00 = 10'b1101010100;
   localparam logic [SYM_W-1:0] TOKEN_01 = 10'b0010101011;
   localparam logic [SYM_W-1:0] TOKEN_10 = 10'b0101010100;
   localparam logic [SYM_W-1:0] TOKEN_11 = 10'b1010101011;

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } align_state_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational decode of one aligned 10-bit TMDS symbol into either a
// control token ({c1,c0}) or an 8-bit data byte.
module tmds_symbol_decode
   import tmds_pkg::*;
(
   input  logic [SYM_W-1:0] sym,
   output logic             is_token,
   output logic [1:0]       ctrl,
   output logic [7:0]       q
);

   logic [7:0] d;

   always_comb begin
      is_token = 1'b1;
      ctrl     = 2'b00;
      case (sym)
         TOKEN_00: ctrl = 2'b00;
         TOKEN_01: ctrl = 2'b01;
         TOKEN_10: ctrl = 2'b10;
         TOKEN_11: ctrl = 2'b11;
         default:  is_token = 1'b0;
      endcase
   end

   // Undo the optional inversion, then the XOR/XNOR transition chain.
   always_comb begin
      d    = sym[9] ? ~sym[7:0] : sym[7:0];
      q    = 8'h00;
      q[0] = d[0];
      for (int i = 1; i < 8; i++) begin
         q[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      end
   end

endmodule

// File: rtl/tmds_decode.sv
// Single-channel TMDS receive decoder: word capture, bit-offset alignment by
// control-token runs, symbol decode and registered output gating.
module tmds_decode
   import tmds_pkg::*;
#(
   parameter int TOKEN_RUN    = 8,
   parameter int SEARCH_WIN   = 2048,
   parameter int LOCK_TIMEOUT = 4096
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic [SYM_W-1:0] raw_data,
   output logic [7:0]       data_out,
   output logic             c0,
   output logic             c1,
   output logic             de,
   output logic             locked,
   output logic [3:0]       bit_offset
);

   localparam int RUN_W = (TOKEN_RUN    > 1) ? $clog2(TOKEN_RUN)    : 1;
   localparam int WIN_W = (SEARCH_WIN   > 1) ? $clog2(SEARCH_WIN)   : 1;
   localparam int TMO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

   function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic [WIN_W-1:0] win_inc(input logic [WIN_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic [TMO_W-1:0] tmo_inc(input logic [TMO_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [SYM_W-1:0]   raw_q;
   logic [SYM_W-1:0]   raw_qq;
   logic [SYM_W-1:0]   word;
   logic               is_token;
   logic [1:0]         ctrl;
   logic [7:0]         q;
   align_state_t       state;
   logic [RUN_W-1:0]   run_cnt;
   logic [WIN_W-1:0]   win_cnt;
   logic [TMO_W-1:0]   tmo_cnt;
   logic               lock_now;
   logic               slip;
   logic               out_gate;

   // Capture: two-word history feeding the offset mux (data path, no reset).
   always_ff @(posedge sys_clk) begin
      raw_q  <= raw_data;
      raw_qq <= raw_q;
   end

   // Extraction: older word in the LSBs, window starts at bit_offset.
   assign word = SYM_W'({raw_q, raw_qq} >> bit_offset);

   tmds_symbol_decode u_sym (
      .sym      (word),
      .is_token (is_token),
      .ctrl     (ctrl),
      .q        (q)
   );

   assign lock_now = (state == SEARCH) && is_token && (run_cnt == RUN_W'(TOKEN_RUN - 1));
   assign slip     = (win_cnt == WIN_W'(SEARCH_WIN - 1));
   // The token completing the run is already treated as locked on output.
   assign out_gate = (state == LOCKED) || lock_now;
   assign locked   = (state == LOCKED);

   // Decode/output stage: FSM, counters and registered outputs.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= SEARCH;
         bit_offset <= 4'd0;
         run_cnt    <= '0;
         win_cnt    <= '0;
         tmo_cnt    <= '0;
         data_out   <= 8'h00;
         c0         <= 1'b0;
         c1         <= 1'b0;
         de         <= 1'b0;
      end else begin
         case (state)
            SEARCH: begin
               win_cnt <= win_inc(win_cnt);
               if (lock_now) begin
                  state   <= LOCKED;
                  tmo_cnt <= '0;
               end else if (slip) begin
                  bit_offset <= (bit_offset == 4'd9) ? 4'd0 : bit_offset + 4'd1;
                  win_cnt    <= '0;
                  run_cnt    <= '0;
               end else begin
                  run_cnt <= is_token ? run_inc(run_cnt) : '0;
               end
            end
            LOCKED: begin
               if (is_token) begin
                  tmo_cnt <= '0;
               end else if (tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1)) begin
                  state   <= SEARCH;
                  run_cnt <= '0;
                  win_cnt <= '0;
               end else begin
                  tmo_cnt <= tmo_inc(tmo_cnt);
               end
            end
            default: state <= SEARCH;
         endcase

         if (!out_gate) begin
            de       <= 1'b0;
            data_out <= 8'h00;
         end else if (is_token) begin
            de       <= 1'b0;
            data_out <= 8'h00;
            c1       <= ctrl[1];
            c0       <= ctrl[0];
         end else begin
            de       <= 1'b1;
            data_out <= q;
         end
      end
   end

endmodule

// File: tb/tb_tmds_decode.sv
// Directed-plus-random bench for tmds_decode, checked every cycle against a
// serial-bitstream reference model of the alignment and decode rules.
module tb_tmds_decode;

   localparam int TR = 8;
   localparam int SW = 2048;
   localparam int LT = 4096;

   localparam logic [9:0] T00 = 10'b1101010100;
   localparam logic [9:0] T01 = 10'b0010101011;
   localparam logic [9:0] T10 = 10'b0101010100;
   localparam logic [9:0] T11 = 10'b1010101011;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic [9:0] raw_data = 10'h000;
   logic [7:0] data_out;
   logic       c0, c1, de, locked;
   logic [3:0] bit_offset;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   bit         bitq[$];
   bit         m_locked;
   int         m_off, m_run, m_win, m_tmo;
   logic [7:0] m_data;
   logic [1:0] m_c;
   logic       m_de;

   // stream generator state
   int         s_idx, s_sh;
   logic [9:0] s_cur, s_nxt;

   // scenario bookkeeping
   logic [9:0] r;
   int         cnt, k, lock_k, nslip, prev_off;
   int         slip_at[3];

   tmds_decode #(.TOKEN_RUN(TR), .SEARCH_WIN(SW), .LOCK_TIMEOUT(LT)) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .raw_data   (raw_data),
      .data_out   (data_out),
      .c0         (c0),
      .c1         (c1),
      .de         (de),
      .locked     (locked),
      .bit_offset (bit_offset)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_tok(input logic [9:0] w);
      return (w == T00) || (w == T01) || (w == T10) || (w == T11);
   endfunction

   function automatic logic [9:0] rand_data();
      logic [9:0] w;
      do w = 10'($urandom); while (is_tok(w));
      return w;
   endfunction

   task automatic ref_decode(input logic [9:0] w, output bit tok, output logic [1:0] c,
                             output logic [7:0] q);
      logic [7:0] d;
      tok = 1'b1;
      c   = 2'b00;
      if (w == T01) c = 2'b01;
      else if (w == T10) c = 2'b10;
      else if (w == T11) c = 2'b11;
      else if (w != T00) tok = 1'b0;
      d    = w[9] ? ~w[7:0] : w[7:0];
      q    = 8'h00;
      q[0] = d[0];
      for (int i = 1; i < 8; i++) q[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
   endtask

   task automatic model_reset();
      m_locked = 1'b0;
      m_off = 0; m_run = 0; m_win = 0; m_tmo = 0;
      m_data = 8'h00; m_c = 2'b00; m_de = 1'b0;
   endtask

   // One clock edge of the model; bitq holds the last 20 received bits, oldest first.
   task automatic model_edge(input logic [9:0] w);
      logic [9:0] ext;
      bit         tok, lock_now;
      logic [1:0] c;
      logic [7:0] q;
      if (!sys_rst_n) begin
         model_reset();
      end else begin
         for (int i = 0; i < 10; i++) ext[i] = bitq[m_off + i];
         ref_decode(ext, tok, c, q);
         lock_now = !m_locked && tok && (m_run + 1 == TR);
         if (m_locked || lock_now) begin
            if (tok) begin m_de = 1'b0; m_data = 8'h00; m_c = c; end
            else begin m_de = 1'b1; m_data = q; end
         end else begin
            m_de = 1'b0; m_data = 8'h00;
         end
         if (!m_locked) begin
            if (lock_now) begin
               m_locked = 1'b1; m_tmo = 0;
            end else if (m_win == SW - 1) begin
               m_off = (m_off + 1) % 10; m_win = 0; m_run = 0;
            end else begin
               m_win++;
               m_run = tok ? m_run + 1 : 0;
            end
         end else begin
            if (tok) m_tmo = 0;
            else if (m_tmo == LT - 1) begin m_locked = 1'b0; m_run = 0; m_win = 0; end
            else m_tmo++;
         end
      end
      for (int i = 0; i < 10; i++) begin
         bitq.push_back(w[i]);
         void'(bitq.pop_front());
      end
   endtask

   task automatic tick(input logic [9:0] w);
      raw_data = w;
      @(posedge sys_clk);
      model_edge(w);
      #1;
      chk("cycle", 32'({data_out, c1, c0, de, locked, bit_offset}),
          32'({m_data, m_c[1], m_c[0], m_de, m_locked, 4'(m_off)}));
   endtask

   function automatic logic [9:0] gen_sym(input int i);
      return (i % 800 < 16) ? T00 : rand_data();
   endfunction

   // Serial stream whose symbols become aligned at bit offset 'target'.
   task automatic stream_init(input int target);
      s_sh  = (10 - target) % 10;
      s_idx = 0;
      s_cur = gen_sym(0);
      s_nxt = gen_sym(1);
   endtask

   task automatic stream_next(output logic [9:0] w);
      logic [19:0] pair;
      pair  = {s_nxt, s_cur} >> s_sh;
      w     = pair[9:0];
      s_cur = s_nxt;
      s_idx++;
      s_nxt = gen_sym(s_idx + 1);
   endtask

   initial begin
      repeat (20) bitq.push_back(1'b0);
      model_reset();

      // 1. reset with random input
      repeat (4) tick(10'($urandom));
      chk("rst_outs", 32'({data_out, c1, c0, de}), 32'h0);
      chk("rst_locked", 32'(locked), 32'h0);
      chk("rst_offset", 32'(bit_offset), 32'h0);
      sys_rst_n = 1'b1;
      repeat (2) tick(rand_data());
      chk("post_rst_locked", 32'(locked), 32'h0);

      // 2. aligned lock and decode
      repeat (8) tick(T00);
      tick(10'h100);
      chk("lock_not_early", 32'(locked), 32'h0);
      tick(10'h2FF);
      chk("lock_rise", 32'(locked), 32'h1);
      chk("lock_ctrl", 32'({c1, c0, de}), 32'b000);
      tick(rand_data());
      chk("dec_100", 32'({de, data_out}), 32'h100);
      tick(rand_data());
      chk("dec_2ff", 32'({de, data_out}), 32'h1FE);

      // 4. token sync then data keeps control bits
      tick(T11);
      cnt = 0;
      tick(rand_data()); cnt++;
      tick(rand_data()); cnt++;
      chk("tok11", 32'({c1, c0, de}), 32'b110);
      tick(rand_data()); cnt++;
      tick(rand_data()); cnt++;
      chk("hold11", 32'({c1, c0, de}), 32'b111);

      // 5. loss of lock
      while (locked && cnt < LT + 50) begin
         tick(rand_data());
         cnt++;
      end
      chk("tmo_len", 32'(cnt), 32'(LT + 2));
      chk("tmo_offset", 32'(bit_offset), 32'h0);
      tick(rand_data());
      chk("tmo_de", 32'({de, data_out}), 32'h0);
      // variant: 8th token lands on the slip cycle
      for (int j = 2; j <= SW - 10; j++) tick(rand_data());
      repeat (8) tick(T00);
      tick(rand_data());
      chk("race_pre", 32'({locked, bit_offset}), 32'h0);
      tick(rand_data());
      chk("race_lock", 32'({locked, bit_offset}), 32'h10);

      // 3. bit-slip acquisition at offset 3
      sys_rst_n = 1'b0;
      repeat (2) tick(10'($urandom));
      sys_rst_n = 1'b1;
      stream_init(3);
      nslip = 0; prev_off = 0; lock_k = 0;
      for (int i = 0; i < 3; i++) slip_at[i] = 0;
      k = 0;
      while (lock_k == 0 && k < 4 * SW + 1000) begin
         k++;
         stream_next(r);
         tick(r);
         if (int'(bit_offset) != prev_off) begin
            if (nslip < 3) slip_at[nslip] = k;
            nslip++;
            prev_off = int'(bit_offset);
         end
         if (locked) lock_k = k;
      end
      chk("slip1", 32'(slip_at[0]), 32'(SW));
      chk("slip2", 32'(slip_at[1]), 32'(2 * SW));
      chk("slip3", 32'(slip_at[2]), 32'(3 * SW));
      chk("acq_offset", 32'(bit_offset), 32'h3);
      chk("acq_window", 32'(lock_k > 3 * SW && lock_k <= 3 * SW + 830), 32'h1);

      // 6. reset mid-operation while locked at offset 5
      sys_rst_n = 1'b0;
      repeat (2) tick(10'($urandom));
      sys_rst_n = 1'b1;
      stream_init(5);
      k = 0;
      while (!locked && k < 6 * SW + 1000) begin
         k++;
         stream_next(r);
         tick(r);
      end
      chk("lock5", 32'({locked, bit_offset}), 32'h15);
      sys_rst_n = 1'b0;
      #1;
      chk("async_rst", 32'({locked, bit_offset, de, data_out}), 32'h0);
      model_reset();
      tick(10'($urandom));
      sys_rst_n = 1'b1;
      repeat (7) tick(T00);
      repeat (3) tick(rand_data());
      chk("short_run", 32'(locked), 32'h0);
      repeat (8) tick(T00);
      tick(rand_data());
      chk("relock_pre", 32'(locked), 32'h0);
      tick(rand_data());
      chk("relock", 32'({locked, bit_offset}), 32'h10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
